// File: rtl/sprite_mem_arbiter.sv
// Sprite memory arbiter: shares one single-ported sprite memory between single-cycle
// CPU accesses and fixed-length GPU read bursts, with a starvation bound on CPU wait.
module sprite_mem_arbiter #(
    parameter int unsigned ADDR_W       = 8,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned GPU_BURST    = 4,
    parameter int unsigned MAX_CPU_WAIT = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_re,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [3:0]        cpu_action,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_stall,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              gpu_req,
    input  logic [ADDR_W-1:0] gpu_addr,
    output logic              gpu_gnt,
    output logic              gpu_rvalid,
    output logic [DATA_W-1:0] gpu_rdata,
    output logic              gpu_done,
    output logic              mem_re,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_action,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int unsigned BEAT_W   = (GPU_BURST > 1) ? $clog2(GPU_BURST) : 1;
    localparam int unsigned STARVE_W = (MAX_CPU_WAIT > 0) ? $clog2(MAX_CPU_WAIT + 1) : 1;
    localparam logic [BEAT_W-1:0]   LAST_BEAT  = BEAT_W'(GPU_BURST - 1);
    localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(MAX_CPU_WAIT);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CPU_ACC = 2'd1,
        S_GPU_RD  = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [STARVE_W-1:0] starve_q, starve_d;
    logic                cpu_rvalid_q, cpu_rvalid_d;
    logic                gpu_rvalid_q, gpu_rvalid_d;
    logic                gpu_done_q, gpu_done_d;
    logic                cpu_pending;
    logic                cpu_starved;

    assign cpu_pending = cpu_re | cpu_we;
    assign cpu_starved = cpu_pending && (starve_q >= STARVE_MAX);
    assign cpu_stall   = cpu_pending && (state_q != S_CPU_ACC);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            beat_q       <= '0;
            base_q       <= '0;
            starve_q     <= '0;
            cpu_rvalid_q <= 1'b0;
            gpu_rvalid_q <= 1'b0;
            gpu_done_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            beat_q       <= beat_d;
            base_q       <= base_d;
            starve_q     <= starve_d;
            cpu_rvalid_q <= cpu_rvalid_d;
            gpu_rvalid_q <= gpu_rvalid_d;
            gpu_done_q   <= gpu_done_d;
        end
    end

    // Arbitration and burst sequencing; the GPU wins ties until the CPU has starved.
    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        base_d  = base_q;
        case (state_q)
            S_IDLE: begin
                if (gpu_req && !cpu_starved) begin
                    state_d = S_GPU_RD;
                    base_d  = gpu_addr;
                    beat_d  = '0;
                end else if (cpu_pending) begin
                    state_d = S_CPU_ACC;
                end
            end
            S_CPU_ACC: state_d = S_IDLE;
            S_GPU_RD: begin
                if (beat_q == LAST_BEAT) begin
                    state_d = S_IDLE;
                    beat_d  = '0;
                end else begin
                    beat_d = beat_q + BEAT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        starve_d = starve_q;
        if (state_q == S_CPU_ACC) begin
            starve_d = '0;
        end else if (cpu_stall && (starve_q != STARVE_MAX)) begin
            starve_d = starve_q + STARVE_W'(1);
        end
    end

    // Memory port mux: CPU access passes its held request straight through.
    always_comb begin
        mem_re     = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_action = '0;
        mem_wdata  = '0;
        case (state_q)
            S_CPU_ACC: begin
                mem_we     = cpu_we;
                mem_re     = cpu_re & ~cpu_we;
                mem_addr   = cpu_addr;
                mem_action = cpu_action;
                mem_wdata  = cpu_wdata;
            end
            S_GPU_RD: begin
                mem_re   = 1'b1;
                mem_addr = base_q + ADDR_W'(beat_q);
            end
            default: ;
        endcase
    end

    always_comb begin
        cpu_rvalid_d = (state_q == S_CPU_ACC) && cpu_re && !cpu_we;
        gpu_rvalid_d = (state_q == S_GPU_RD);
        gpu_done_d   = (state_q == S_GPU_RD) && (beat_q == LAST_BEAT);
    end

    assign cpu_rvalid = cpu_rvalid_q;
    assign cpu_rdata  = cpu_rvalid_q ? mem_rdata : '0;
    assign gpu_gnt    = (state_q == S_GPU_RD);
    assign gpu_rvalid = gpu_rvalid_q;
    assign gpu_rdata  = gpu_rvalid_q ? mem_rdata : '0;
    assign gpu_done   = gpu_done_q;

endmodule

// File: tb/tb_sprite_mem_arbiter.sv
// Directed bench for sprite_mem_arbiter with a small behavioural sprite memory.
module tb_sprite_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cpu_re, cpu_we;
    logic [7:0]  cpu_addr;
    logic [3:0]  cpu_action;
    logic [31:0] cpu_wdata;
    logic        cpu_stall, cpu_rvalid;
    logic [31:0] cpu_rdata;
    logic        gpu_req;
    logic [7:0]  gpu_addr;
    logic        gpu_gnt, gpu_rvalid, gpu_done;
    logic [31:0] gpu_rdata;
    logic        mem_re, mem_we;
    logic [7:0]  mem_addr;
    logic [3:0]  mem_action;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic [31:0] mem [256];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    sprite_mem_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_re(cpu_re), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_action(cpu_action), .cpu_wdata(cpu_wdata),
        .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .gpu_req(gpu_req), .gpu_addr(gpu_addr), .gpu_gnt(gpu_gnt),
        .gpu_rvalid(gpu_rvalid), .gpu_rdata(gpu_rdata), .gpu_done(gpu_done),
        .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_action(mem_action), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // Sprite memory: contents 0x5A0000aa except 0x40, reloaded while in reset.
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'h5A00_0000 | 32'(i);
            mem[8'h40] <= 32'h0000_A5A5;
            mem_rdata  <= '0;
        end else begin
            if (mem_re) mem_rdata <= mem[mem_addr];
            if (mem_we) mem[mem_addr] <= mem_wdata;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        cpu_re = 0; cpu_we = 0; cpu_addr = 0; cpu_action = 0; cpu_wdata = 0;
        gpu_req = 0; gpu_addr = 0;
        repeat (3) tick;
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({gpu_gnt, mem_re, mem_we, cpu_rvalid, gpu_rvalid, gpu_done, cpu_stall} !== 7'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got gnt/re/we/crv/grv/done/stall=%b required 0000000",
                     {gpu_gnt, mem_re, mem_we, cpu_rvalid, gpu_rvalid, gpu_done, cpu_stall});
        end
        checks++;
        if ({mem_addr, mem_action, mem_wdata} !== 44'h0) begin
            errors++;
            $display("FAIL reset_mem_bus: got addr=%h act=%h wdata=%h required 0", mem_addr, mem_action, mem_wdata);
        end
        cpu_re = 1'b1;
        #1;
        checks++;
        if (cpu_stall !== 1'b1) begin
            errors++; $display("FAIL reset_stall_follow: got %b required 1", cpu_stall);
        end
        cpu_re = 1'b0;
        tick;
    endtask

    task automatic test_idle_write;
        cpu_we = 1; cpu_addr = 8'h12; cpu_action = 4'h3; cpu_wdata = 32'hDEADBEEF;
        @(negedge clk);
        checks++;
        if (cpu_stall !== 1'b1 || mem_we !== 1'b0) begin
            errors++; $display("FAIL write_c0: got stall=%b we=%b required stall=1 we=0", cpu_stall, mem_we);
        end
        tick;
        @(negedge clk);
        checks++;
        if ({mem_we, mem_re, mem_addr, mem_action, mem_wdata, cpu_stall} !== {1'b1, 1'b0, 8'h12, 4'h3, 32'hDEADBEEF, 1'b0}) begin
            errors++;
            $display("FAIL write_c1: got we=%b re=%b addr=%h act=%h wd=%h stall=%b required 1 0 12 3 deadbeef 0",
                     mem_we, mem_re, mem_addr, mem_action, mem_wdata, cpu_stall);
        end
        tick;
        cpu_we = 0;
        @(negedge clk);
        checks++;
        if ({mem_we, mem_re, gpu_gnt, cpu_stall, cpu_rvalid} !== 5'b0 || mem[8'h12] !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL write_c2: got we=%b re=%b gnt=%b stall=%b rv=%b mem12=%h required 0s and deadbeef",
                     mem_we, mem_re, gpu_gnt, cpu_stall, cpu_rvalid, mem[8'h12]);
        end
        tick;
    endtask

    task automatic test_idle_read;
        cpu_re = 1; cpu_addr = 8'h40;
        @(negedge clk);
        checks++;
        if (cpu_stall !== 1'b1 || mem_re !== 1'b0) begin
            errors++; $display("FAIL read_c0: got stall=%b re=%b required 1 0", cpu_stall, mem_re);
        end
        tick;
        @(negedge clk);
        checks++;
        if (cpu_stall !== 1'b0 || mem_re !== 1'b1 || mem_addr !== 8'h40 || cpu_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL read_c1: got stall=%b re=%b addr=%h rv=%b required 0 1 40 0", cpu_stall, mem_re, mem_addr, cpu_rvalid);
        end
        tick;
        cpu_re = 0;
        @(negedge clk);
        checks++;
        if (cpu_rvalid !== 1'b1 || cpu_rdata !== 32'h0000A5A5) begin
            errors++; $display("FAIL read_c2: got rv=%b rdata=%h required 1 0000a5a5", cpu_rvalid, cpu_rdata);
        end
        tick;
        @(negedge clk);
        checks++;
        if (cpu_rvalid !== 1'b0 || cpu_rdata !== 32'h0) begin
            errors++; $display("FAIL read_c3: got rv=%b rdata=%h required 0 0", cpu_rvalid, cpu_rdata);
        end
    endtask

    task automatic test_back_to_back;
        logic [3:0] exp_we;
        logic [3:0] exp_stall;
        exp_we    = 4'b1010;
        exp_stall = 4'b0101;
        tick;
        cpu_we = 1; cpu_addr = 8'h50; cpu_action = 4'h1; cpu_wdata = 32'h1111_0000;
        for (int c = 0; c < 4; c++) begin
            if (c == 2) begin cpu_addr = 8'h51; cpu_wdata = 32'h2222_0000; end
            @(negedge clk);
            checks++;
            if (mem_we !== exp_we[c] || cpu_stall !== exp_stall[c]) begin
                errors++;
                $display("FAIL b2b_c%0d: got we=%b stall=%b required %b %b", c, mem_we, cpu_stall, exp_we[c], exp_stall[c]);
            end
            tick;
        end
        cpu_we = 0;
        checks++;
        if (mem[8'h50] !== 32'h1111_0000 || mem[8'h51] !== 32'h2222_0000) begin
            errors++; $display("FAIL b2b_mem: got %h %h required 11110000 22220000", mem[8'h50], mem[8'h51]);
        end
    endtask

    task automatic test_gpu_burst;
        logic [7:0]  exp_addr [4];
        logic [31:0] exp_data [4];
        exp_addr = '{8'hFE, 8'hFF, 8'h00, 8'h01};
        exp_data = '{32'h5A0000FE, 32'h5A0000FF, 32'h5A000000, 32'h5A000001};
        tick;
        gpu_req = 1; gpu_addr = 8'hFE;
        @(negedge clk);
        checks++;
        if (gpu_gnt !== 1'b0 || mem_re !== 1'b0) begin
            errors++; $display("FAIL burst_req: got gnt=%b re=%b required 0 0", gpu_gnt, mem_re);
        end
        for (int b = 0; b < 4; b++) begin
            tick;
            gpu_req = 0;
            @(negedge clk);
            checks++;
            if (gpu_gnt !== 1'b1 || mem_re !== 1'b1 || mem_we !== 1'b0 || mem_addr !== exp_addr[b] || gpu_done !== 1'b0) begin
                errors++;
                $display("FAIL burst_beat%0d: got gnt=%b re=%b we=%b addr=%h done=%b required 1 1 0 %h 0",
                         b, gpu_gnt, mem_re, mem_we, mem_addr, gpu_done, exp_addr[b]);
            end
            checks++;
            if (gpu_rvalid !== (b > 0) || (b > 0 && gpu_rdata !== exp_data[(b > 0) ? b - 1 : 0])) begin
                errors++; $display("FAIL burst_rv%0d: got rv=%b data=%h", b, gpu_rvalid, gpu_rdata);
            end
        end
        tick;
        @(negedge clk);
        checks++;
        if ({gpu_gnt, mem_re, gpu_rvalid, gpu_done} !== 4'b0011 || gpu_rdata !== exp_data[3]) begin
            errors++;
            $display("FAIL burst_last: got gnt=%b re=%b rv=%b done=%b data=%h required 0 0 1 1 %h",
                     gpu_gnt, mem_re, gpu_rvalid, gpu_done, gpu_rdata, exp_data[3]);
        end
        tick;
        @(negedge clk);
        checks++;
        if ({gpu_rvalid, gpu_done} !== 2'b00 || gpu_rdata !== 32'h0) begin
            errors++; $display("FAIL burst_after: got rv=%b done=%b data=%h required 0 0 0", gpu_rvalid, gpu_done, gpu_rdata);
        end
    endtask

    task automatic test_priority;
        tick;
        gpu_req = 1; gpu_addr = 8'h80;
        cpu_we = 1; cpu_addr = 8'h60; cpu_action = 4'h7; cpu_wdata = 32'hCAFE0001;
        for (int c = 0; c < 7; c++) begin
            if (c == 1) gpu_req = 0;
            @(negedge clk);
            checks++;
            if (gpu_gnt !== (c >= 1 && c <= 4) || mem_we !== (c == 6) || cpu_stall !== (c != 6)) begin
                errors++;
                $display("FAIL prio_c%0d: got gnt=%b we=%b stall=%b", c, gpu_gnt, mem_we, cpu_stall);
            end
            tick;
        end
        cpu_we = 0;
    endtask

    task automatic test_starvation;
        int found;
        int stalls;
        found  = -1;
        stalls = 0;
        tick;
        gpu_req = 1; gpu_addr = 8'h10;
        cpu_re = 1; cpu_addr = 8'h40;
        for (int c = 0; c < 20 && found < 0; c++) begin
            if (c > 0) tick;
            @(negedge clk);
            if (mem_re && !gpu_gnt) found = c;
            else if (cpu_stall) stalls++;
        end
        checks++;
        if (found != 11 || stalls != 11) begin
            errors++; $display("FAIL starve_bound: got acc_cycle=%0d stalls=%0d required 11 11", found, stalls);
        end
        checks++;
        if (cpu_stall !== 1'b0 || mem_addr !== 8'h40) begin
            errors++; $display("FAIL starve_acc: got stall=%b addr=%h required 0 40", cpu_stall, mem_addr);
        end
        tick;
        cpu_re = 0;
        @(negedge clk);
        checks++;
        if (gpu_gnt !== 1'b0 || cpu_rvalid !== 1'b1 || cpu_rdata !== 32'h0000A5A5) begin
            errors++; $display("FAIL starve_idle: got gnt=%b rv=%b data=%h required 0 1 0000a5a5", gpu_gnt, cpu_rvalid, cpu_rdata);
        end
        tick;
        @(negedge clk);
        checks++;
        if (gpu_gnt !== 1'b1 || mem_addr !== 8'h10) begin
            errors++; $display("FAIL starve_gpu_resume: got gnt=%b addr=%h required 1 10", gpu_gnt, mem_addr);
        end
        tick;
        gpu_req = 0;
        for (int c = 0; c < 10 && gpu_gnt; c++) tick;
        checks++;
        if (gpu_gnt !== 1'b0) begin
            errors++; $display("FAIL starve_drain: got gnt=%b required 0", gpu_gnt);
        end
        tick;
    endtask

    task automatic test_reset_mid_burst;
        gpu_req = 1; gpu_addr = 8'h20;
        tick;
        gpu_req = 0;
        tick;
        tick;
        rst_n = 0;
        @(negedge clk);
        checks++;
        if (gpu_gnt !== 1'b1 || mem_addr !== 8'h22) begin
            errors++; $display("FAIL rst_burst_beat2: got gnt=%b addr=%h required 1 22", gpu_gnt, mem_addr);
        end
        tick;
        rst_n = 1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checks++;
            if ({gpu_gnt, mem_re, gpu_rvalid, gpu_done} !== 4'b0) begin
                errors++;
                $display("FAIL rst_burst_after%0d: got gnt=%b re=%b rv=%b done=%b required 0 0 0 0",
                         c, gpu_gnt, mem_re, gpu_rvalid, gpu_done);
            end
            tick;
        end
    endtask

    task automatic test_conflict;
        cpu_re = 1; cpu_we = 1; cpu_addr = 8'h33; cpu_action = 4'h5; cpu_wdata = 32'h12345678;
        @(negedge clk);
        checks++;
        if (cpu_stall !== 1'b1) begin
            errors++; $display("FAIL conflict_c0: got stall=%b required 1", cpu_stall);
        end
        tick;
        @(negedge clk);
        checks++;
        if (mem_we !== 1'b1 || mem_re !== 1'b0 || mem_addr !== 8'h33 || mem_action !== 4'h5) begin
            errors++;
            $display("FAIL conflict_c1: got we=%b re=%b addr=%h act=%h required 1 0 33 5", mem_we, mem_re, mem_addr, mem_action);
        end
        tick;
        cpu_re = 0; cpu_we = 0;
        @(negedge clk);
        checks++;
        if (cpu_rvalid !== 1'b0 || mem[8'h33] !== 32'h12345678) begin
            errors++; $display("FAIL conflict_c2: got rv=%b mem33=%h required 0 12345678", cpu_rvalid, mem[8'h33]);
        end
        tick;
    endtask

    initial begin
        test_reset;
        test_idle_write;
        test_idle_read;
        test_back_to_back;
        test_gpu_burst;
        test_priority;
        test_starvation;
        test_reset_mid_burst;
        test_conflict;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
